// File: rtl/microcode_sequencer.sv
// Microcode sequencer: walks an {opcode, micro-op count} ROM address, stalls on
// unfinished MMU accesses, loads new opcodes and traps counter overflow.
module microcode_sequencer #(
  parameter int unsigned OPCODE_W = 6,
  parameter int unsigned COUNT_W  = 5
) (
  input  logic                         CLK,
  input  logic                         RST,
  output logic [OPCODE_W+COUNT_W-1:0]  ADDR,
  input  logic [31:0]                  UCODE,
  input  logic [OPCODE_W-1:0]          OPWORD_OPCODE,
  input  logic [OPCODE_W-1:0]          BUS_OPCODE,
  input  logic                         MMU_READY,
  output logic [OPCODE_W-1:0]          OPCODE,
  output logic [COUNT_W-1:0]           MICROOP_COUNT,
  output logic                         IN_EN,
  output logic                         STALL,
  output logic                         INSTR_START,
  output logic                         FAULT
);

  localparam logic [2:0] IN_OPCODE = 3'd6;
  localparam logic [2:0] IN_MMU    = 3'd4;
  localparam logic [3:0] OUT_MMU   = 4'd4;
  localparam logic [COUNT_W-1:0] COUNT_MAX = '1;

  typedef enum logic {RUN, FAULTED} state_t;

  state_t               state, state_nxt;
  logic [OPCODE_W-1:0]  opcode_q, opcode_nxt;
  logic [COUNT_W-1:0]   count_q, count_nxt;

  logic [2:0] in_plane;
  logic [3:0] out_plane;
  logic       misc;
  logic       opcode_sel;
  logic       mem_access;
  logic       unused_ucode;

  assign in_plane     = UCODE[14:12];
  assign out_plane    = UCODE[11:8];
  assign misc         = UCODE[15];
  assign opcode_sel   = UCODE[22];
  assign mem_access   = (in_plane == IN_MMU) || (out_plane == OUT_MMU);
  assign unused_ucode = ^{UCODE[31:23], UCODE[21:16], UCODE[7:0]};

  assign ADDR          = {opcode_q, count_q};
  assign OPCODE        = opcode_q;
  assign MICROOP_COUNT = count_q;
  assign FAULT         = (state == FAULTED);

  // State and sequencing registers; reset wins over any completion or stall.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= RUN;
      opcode_q <= '0;
      count_q  <= '0;
    end else begin
      state    <= state_nxt;
      opcode_q <= opcode_nxt;
      count_q  <= count_nxt;
    end
  end

  // Next-state and per-cycle strobes for the micro-op currently addressed.
  always_comb begin
    state_nxt   = state;
    opcode_nxt  = opcode_q;
    count_nxt   = count_q;
    IN_EN       = 1'b0;
    STALL       = 1'b0;
    INSTR_START = 1'b0;
    if (!RST) begin
      case (state)
        RUN: begin
          if (mem_access && !MMU_READY) begin
            STALL = 1'b1;
          end else begin
            IN_EN = (in_plane != 3'd0);
            // Overflow traps instead of wrapping; the pending opcode load is dropped.
            if (!misc && (count_q == COUNT_MAX)) begin
              state_nxt = FAULTED;
            end else begin
              count_nxt = misc ? '0 : count_q + COUNT_W'(1);
              if (in_plane == IN_OPCODE) begin
                opcode_nxt  = opcode_sel ? BUS_OPCODE : OPWORD_OPCODE;
                INSTR_START = !opcode_sel;
              end
            end
          end
        end
        FAULTED: begin
          state_nxt = FAULTED;
        end
        default: begin
          state_nxt = RUN;
        end
      endcase
    end
  end

endmodule

// File: doc/microcode_sequencer.md
MICROCODE_SEQUENCER -- requirements
Module: microcode_sequencer

Interface
REQ-001 Parameter OPCODE_W, default 6, opcode register width; SHALL equal the ROM address opcode field width.
REQ-002 Parameter COUNT_W, default 5, micro-op counter width; SHALL equal the ROM address counter field width.
REQ-003 Port CLK, input, 1, sole clock; all state SHALL update on its rising edge.
REQ-004 Port RST, input, 1, synchronous active-high reset, sampled on the CLK rising edge.
REQ-005 Port ADDR, output, 11, microcode ROM address = {OPCODE, MICROOP_COUNT}.
REQ-006 Port UCODE, input, 32, control word returned combinationally by the ROM for the current ADDR.
REQ-007 Port OPWORD_OPCODE, input, 6, opword register bits [31:26].
REQ-008 Port BUS_OPCODE, input, 6, data bus bits [5:0].
REQ-009 Port MMU_READY, input, 1, high when the MMU completes the current access this cycle.
REQ-010 Port OPCODE, output, 6, current opcode register.
REQ-011 Port MICROOP_COUNT, output, 5, current micro-op counter.
REQ-012 Port IN_EN, output, 1, destination write strobe; the in-plane target captures on the edge ending a cycle with IN_EN high.
REQ-013 Port STALL, output, 1, high while a micro-op is held waiting on the MMU.
REQ-014 Port INSTR_START, output, 1, one-cycle pulse when an opcode is loaded from OPWORD_OPCODE.
REQ-015 Port FAULT, output, 1, sticky micro-op counter overflow flag.

Function
REQ-016 UCODE field decode SHALL be: in_plane=UCODE[14:12], out_plane=UCODE[11:8], misc=UCODE[15], opcode_sel=UCODE[22]; IN_OPCODE=6, IN_MMU/OUT_MMU=4.
REQ-017 States SHALL be RUN and FAULTED; reset enters RUN.
REQ-018 A micro-op SHALL be a memory access when out_plane==4 or in_plane==4.
REQ-019 RUN, memory access with MMU_READY low: STALL=1, IN_EN=0, OPCODE and MICROOP_COUNT held.
REQ-020 RUN, otherwise: STALL=0; IN_EN=1 iff in_plane!=0; the micro-op completes at the edge.
REQ-021 On completion with misc==1: MICROOP_COUNT SHALL become 0.
REQ-022 On completion with misc==0: MICROOP_COUNT SHALL increment by 1.
REQ-023 On completion with in_plane==6: OPCODE SHALL load BUS_OPCODE if opcode_sel==1, else OPWORD_OPCODE; this is independent of misc, so a load without misc loads the opcode and also increments.
REQ-024 INSTR_START SHALL be high in the completing cycle iff in_plane==6 and opcode_sel==0.
REQ-025 On completion with misc==0 and MICROOP_COUNT==31: the transition SHALL go to FAULTED, the counter holding 31 with no wrap, and the opcode load of REQ-023 suppressed.
REQ-026 FAULTED: FAULT=1, IN_EN=0, STALL=0, INSTR_START=0, OPCODE and MICROOP_COUNT frozen; only RST exits.
REQ-027 An all-zero UCODE (unused ROM slot) SHALL advance the counter with IN_EN=0 and eventually fault per REQ-025.
REQ-028 ADDR SHALL be a pure combinational concatenation of the registers, with zero-cycle latency.
REQ-029 MMU_READY SHALL be ignored for non-memory micro-ops.

Reset
REQ-030 RST high at an edge SHALL set OPCODE=0 (RESET), MICROOP_COUNT=0, FAULT=0 and state RUN, overriding any completion or stall in that cycle.
REQ-031 While RST is high, IN_EN, STALL and INSTR_START SHALL be forced 0.
REQ-032 Reset asserted mid-stall or in FAULTED SHALL recover identically to power-up on the next edge.

Verification
REQ-033 Reset then the real ROM: ADDR sequence 0x000, 0x001, then 0x020 (FETCH count 0); after the FETCH count-4 micro-op, OPCODE = OPWORD_OPCODE, INSTR_START pulses once, and the count is 0.
REQ-034 FETCH count 1 with MMU_READY low for 3 cycles: STALL=1 for 3 cycles, IN_EN=0, ADDR steady at 0x021; advances to 0x022 on the ready cycle.
REQ-035 UCODE=0x0000_6000 (in_plane=6, opcode_sel=0, misc=0) with OPWORD_OPCODE=0x02: OPCODE=2 and the count increments by 1.
REQ-036 UCODE held at 0 from count 0: count reaches 31, then FAULT=1 at the next edge and ADDR frozen; RST returns ADDR to 0x000 with FAULT=0.
REQ-037 RST asserted while STALL=1: the next cycle gives OPCODE=0, count 0, STALL=0.
